// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the decoder that consumes its words.
package fetch_unit_pkg;

    // Fetch control states: FETCH assembles bytes, HOLD presents a finished word.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam int ADDR_W_DEF      = 8;
    localparam int INSTR_BYTES_DEF = 4;
    localparam int BOOT_PC_DEF     = 0;

    // Bit width of an instruction built from nbytes bytes.
    function automatic int instr_width(input int nbytes);
        return 8 * nbytes;
    endfunction

    localparam int INSTR_W = instr_width(INSTR_BYTES_DEF);

endpackage

// File: rtl/fetch_byte_assembler.sv
// Collects bytes into numbered slots and presents them as one little-endian word.
// Slot i drives bits [8i+7:8i]; usable for instruction fetch or multi-byte loads.
module fetch_byte_assembler
    import fetch_unit_pkg::*;
#(
    parameter int NBYTES = INSTR_BYTES_DEF,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [7:0]            byte_in,
    output logic [8*NBYTES-1:0]   word
);

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_slot
            logic [7:0] slot_q;

            // Capture the incoming byte when this slot is addressed; clear on reset.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    slot_q <= 8'h00;
                end else if (we && (idx == IDX_W'(gi))) begin
                    slot_q <= byte_in;
                end
            end

            assign word[8*gi +: 8] = slot_q;
        end
    endgenerate

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a byte address through the RAM/boot-ROM mux,
// assembles INSTR_BYTES bytes into a word, and hands it to the decoder with a
// valid/ready handshake. Jumps redirect fetch and select RAM or ROM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int BOOT_PC     = BOOT_PC_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_read_from_ram,
    input  logic [7:0]               mem_data,
    output logic [8*INSTR_BYTES-1:0] instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     jump_valid,
    input  logic [ADDR_W-1:0]        jump_addr,
    input  logic                     jump_to_ram
);

    localparam int IDX_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [IDX_W-1:0]  idx_q;
    logic              ram_sel_q;
    logic              valid_q;

    logic [ADDR_W-1:0] pc_step_d;
    logic [IDX_W-1:0]  idx_inc_d;
    logic              byte_we;

    // Next-PC and next-index arithmetic; PC wraps modulo 2^ADDR_W.
    always_comb begin
        pc_step_d = pc_q + ADDR_W'(INSTR_BYTES);
        idx_inc_d = idx_q + IDX_W'(1);
    end

    // Byte slots are only written while fetching; a jump cycle's byte is dropped.
    assign byte_we = (state_q == FETCH) && reset_n && !jump_valid;

    // Fetch/hold sequencer with jump redirect; reset, then jump, take priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            pc_q      <= ADDR_W'(BOOT_PC);
            idx_q     <= '0;
            ram_sel_q <= 1'b0;
            valid_q   <= 1'b0;
        end else if (jump_valid) begin
            // A held word accepted this same cycle is owned by the decoder;
            // the jump still decides where fetch resumes.
            state_q   <= FETCH;
            pc_q      <= jump_addr;
            idx_q     <= '0;
            ram_sel_q <= jump_to_ram;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_inc_d;
                    end
                end
                HOLD: begin
                    if (valid_q && instr_ready) begin
                        pc_q    <= pc_step_d;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign mem_address       = pc_q + ADDR_W'(idx_q);
    assign mem_read_from_ram = ram_sel_q;
    assign instr_pc          = pc_q;
    assign instr_valid       = valid_q;

    fetch_byte_assembler #(
        .NBYTES (INSTR_BYTES),
        .IDX_W  (IDX_W)
    ) u_asm (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (byte_we),
        .idx     (idx_q),
        .byte_in (mem_data),
        .word    (instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a table of jump
// targets, and randomized ready/jump traffic against a byte-level memory model.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [7:0]  mem_address;
    logic        mem_read_from_ram;
    logic [7:0]  mem_data;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_valid;
    logic [7:0]  jump_addr;
    logic        jump_to_ram;

    logic [7:0] rom [256];
    logic [7:0] ram [256];

    int total = 0;
    int bad   = 0;
    int dut_hs = 0;

    // Reference model: start address of the instruction being fetched, memory
    // select, and number of fetch cycles elapsed (4 means a word is presented).
    logic [7:0] m_pc  = 8'h00;
    logic       m_sel = 1'b0;
    int         m_k   = 0;

    fetch_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mem_address       (mem_address),
        .mem_read_from_ram (mem_read_from_ram),
        .mem_data          (mem_data),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .jump_valid        (jump_valid),
        .jump_addr         (jump_addr),
        .jump_to_ram       (jump_to_ram)
    );

    assign mem_data = mem_read_from_ram ? ram[mem_address] : rom[mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && instr_valid && instr_ready) dut_hs++;
    end

    function automatic logic [31:0] word_at(input logic [7:0] a, input logic s);
        logic [31:0] w;
        logic [7:0]  ad;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ad = a + 8'(i);
            w[8*i +: 8] = s ? ram[ad] : rom[ad];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs (at negedge), advance the model, check outputs at next negedge.
    task automatic cycle(input logic rst, input logic jv, input logic [7:0] ja,
                         input logic jr, input logic rdy);
        logic [7:0] exp_addr;
        reset_n = rst; jump_valid = jv; jump_addr = ja; jump_to_ram = jr; instr_ready = rdy;
        if (rst && m_k == 4 && rdy)
            $display("accept pc=%h sel=%0d instr=%h jump=%0d", m_pc, m_sel, instr, jv);
        @(posedge clk);
        if (!rst) begin
            m_pc = 8'h00; m_sel = 1'b0; m_k = 0;
        end else if (jv) begin
            m_pc = ja; m_sel = jr; m_k = 0;
        end else if (m_k == 4) begin
            if (rdy) begin
                m_pc = m_pc + 8'd4; m_k = 0;
            end
        end else begin
            m_k++;
        end
        @(negedge clk);
        exp_addr = (m_k == 4) ? m_pc : m_pc + 8'(m_k);
        chk("valid", {31'b0, instr_valid}, {31'b0, (m_k == 4)});
        chk("mem_address", {24'b0, mem_address}, {24'b0, exp_addr});
        chk("ram_sel", {31'b0, mem_read_from_ram}, {31'b0, m_sel});
        if (m_k == 4) begin
            chk("instr_pc", {24'b0, instr_pc}, {24'b0, m_pc});
            chk("instr", instr, word_at(m_pc, m_sel));
        end
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!instr_valid && n < max_cycles) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        if (!instr_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        to_ram;
        logic [31:0] exp_word;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int h0;
        logic [7:0] tgt_addr [6];
        logic       tgt_ram  [6];

        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($urandom);
            ram[i] = 8'($urandom);
        end
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;

        tgt_addr[0] = 8'h00; tgt_ram[0] = 1'b1;
        tgt_addr[1] = 8'h7F; tgt_ram[1] = 1'b0;
        tgt_addr[2] = 8'hFD; tgt_ram[2] = 1'b1;
        tgt_addr[3] = 8'hFF; tgt_ram[3] = 1'b0;
        tgt_addr[4] = 8'h21; tgt_ram[4] = 1'b1;
        tgt_addr[5] = 8'hC4; tgt_ram[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vecs[i].addr     = tgt_addr[i];
            vecs[i].to_ram   = tgt_ram[i];
            vecs[i].exp_word = word_at(tgt_addr[i], tgt_ram[i]);
            vecs[i].exp_pc   = tgt_addr[i];
        end

        reset_n = 1'b0; jump_valid = 1'b0; jump_addr = 8'h00; jump_to_ram = 1'b0; instr_ready = 1'b0;
        @(negedge clk);

        // Reset state.
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_pc", {24'b0, instr_pc}, 32'h0);

        // First instruction from boot ROM, 4 cycles after reset release.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_instr", instr, 32'h44332211);

        // Hold for 5 cycles, then accept; fetch resumes at 0x04.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold_instr", instr, 32'h44332211);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("after_accept_addr", {24'b0, mem_address}, 32'h04);

        // Jump to RAM 0x40 at idx=2: partial word dropped.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
        chk("jump_addr", {24'b0, mem_address}, 32'h40);
        chk("jump_sel", {31'b0, mem_read_from_ram}, 32'd1);
        wait_valid(8);
        chk("jump_instr_pc", {24'b0, instr_pc}, 32'h40);
        chk("jump_instr", instr, {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]});

        // Wrap-around at 0xFE.
        cycle(1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        wait_valid(8);
        chk("wrap_instr_pc", {24'b0, instr_pc}, 32'hFE);
        chk("wrap_instr", instr, {rom[8'h01], rom[8'h00], rom[8'hFF], rom[8'hFE]});
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("wrap_next_addr", {24'b0, mem_address}, 32'h02);

        // Jump coincident with accept: one handshake, resume at jump target.
        wait_valid(8);
        h0 = dut_hs;
        cycle(1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
        chk("coinc_handshakes", 32'(dut_hs - h0), 32'd1);
        wait_valid(8);
        chk("coinc_instr_pc", {24'b0, instr_pc}, 32'h80);

        // Reset while holding a RAM word.
        cycle(1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
        wait_valid(8);
        chk("pre_reset_sel", {31'b0, mem_read_from_ram}, 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold_reset_valid", {31'b0, instr_valid}, 32'd0);
        chk("hold_reset_addr", {24'b0, mem_address}, 32'h00);
        chk("hold_reset_sel", {31'b0, mem_read_from_ram}, 32'd0);

        // Table of jump targets.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, vecs[i].addr, vecs[i].to_ram, 1'b0);
            wait_valid(8);
            chk("tbl_instr", instr, vecs[i].exp_word);
            chk("tbl_pc", {24'b0, instr_pc}, {24'b0, vecs[i].exp_pc});
            chk("tbl_sel", {31'b0, mem_read_from_ram}, {31'b0, vecs[i].to_ram});
        end

        // Randomized ready and jump traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1, ($urandom_range(0, 19) == 0), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the RAM/boot-ROM read mux.
- Drives the mux's 8-bit byte address and its RAM/ROM select.
- Reads one byte per cycle and assembles INSTR_BYTES bytes into one instruction word.
- Presents the word to the decoder with a valid/ready handshake; supports jumps and the boot-ROM-to-RAM switch.

Parameters:
- ADDR_W, 8, byte address width; all PC arithmetic is modulo 2^ADDR_W.
- INSTR_BYTES, 4, bytes per instruction; instruction width is 8*INSTR_BYTES.
- BOOT_PC, 0, PC loaded at reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- mem_address  output  ADDR_W  byte address to the RAM/ROM mux.
- mem_read_from_ram  output  1  1 = RAM, 0 = boot ROM; drives the mux select.
- mem_data  input  8  byte returned by the mux, combinational from mem_address within the same cycle.
- instr  output  8*INSTR_BYTES  assembled instruction; byte at PC+i occupies bits [8i+7:8i].
- instr_pc  output  ADDR_W  address of the instruction's first byte.
- instr_valid  output  1  instr/instr_pc are stable and valid.
- instr_ready  input  1  decoder accepts when instr_valid && instr_ready at the edge.
- jump_valid  input  1  redirect request, 1-cycle pulse or held.
- jump_addr  input  ADDR_W  redirect target; need not be aligned.
- jump_to_ram  input  1  new mem_read_from_ram value, taken with the jump.

Behaviour:
- Registers: pc, byte index idx (0..INSTR_BYTES-1), state {FETCH, HOLD}, ram_sel, instr shift/slot register, instr_valid.
- mem_address = (pc + idx) mod 2^ADDR_W, combinational from registers only. mem_read_from_ram = ram_sel.
- Reset (reset_n=0 at edge):
  - pc=BOOT_PC, idx=0, state=FETCH, ram_sel=0 (boot ROM).
  - instr=0, instr_valid=0.
  - Hence mem_address=BOOT_PC and instr_pc=BOOT_PC.
  - Reset asserted mid-fetch or in HOLD discards all partial or held data.
- FETCH:
  - Each edge, capture mem_data into byte slot idx.
  - If idx < INSTR_BYTES-1: idx++.
  - Else: idx=0, state=HOLD, instr_valid=1.
- HOLD:
  - instr, instr_pc and mem_address stay stable.
  - On accept (instr_valid && instr_ready): pc += INSTR_BYTES (wraps), instr_valid=0, state=FETCH.
  - Without ready: hold indefinitely.
- Latency: first instr_valid rises at the edge ending the INSTR_BYTES-th FETCH cycle, i.e. 4 cycles after reset release for the default.
- Throughput: one instruction per INSTR_BYTES+1 cycles with ready held high.
- Jump has highest priority after reset and applies in any state: pc=jump_addr, ram_sel=jump_to_ram, idx=0, state=FETCH, instr_valid=0.
  - A partially assembled instruction is discarded.
  - A held instruction with instr_ready=1 in the same cycle counts as accepted (decoder owns it), but the next PC is jump_addr, not pc+INSTR_BYTES.
- Wrap-around: an instruction at 0xFE fetches 0xFE, 0xFF, 0x00, 0x01. instr_pc=0xFE. The next pc is 0x02.
- ram_sel changes only by jump or reset; it never toggles mid-instruction otherwise.
- instr is never updated while instr_valid=1. Slots are overwritten during FETCH; instr is don't-care while instr_valid=0.

Decomposition:
- Shared package: state encoding (FETCH, HOLD), INSTR_BYTES default, BOOT_PC default, and the instruction-width constant, all reused by the decoder.
- One natural sub-module: fetch_byte_assembler. It holds slot registers written by (idx, byte, we) and the output word, and is reusable for multi-byte data loads.
- The PC, handshake and jump control stay in fetch_unit.

Test Plan:
- Reset release, ROM model bytes 0x00..0x03 = 11,22,33,44, ready=1 -> mem_address steps 0,1,2,3; instr_valid rises cycle 4 with instr=0x44332211, instr_pc=0x00, mem_read_from_ram=0.
- Hold ready=0 for 5 cycles after valid -> instr, instr_pc and mem_address unchanged throughout; ready=1 -> next fetch starts at 0x04.
- jump_valid with jump_addr=0x40, jump_to_ram=1 asserted at idx=2 -> partial discarded; mem_address=0x40 next cycle; mem_read_from_ram=1; first valid instr_pc=0x40 with RAM bytes.
- Jump to 0xFE -> bytes fetched from 0xFE, 0xFF, 0x00, 0x01; instr_pc=0xFE; next fetch begins at 0x02.
- Jump coincident with HOLD accept -> exactly one handshake counted; next instr_pc = jump_addr.
- reset_n=0 during HOLD with ram_sel=1 -> next cycle instr_valid=0, mem_address=BOOT_PC, mem_read_from_ram=0.
